// File: rtl/vn_flit_reassembler_pkg.sv
// -----------------------------------------------------------------------------
// Type definitions for the per-virtual-network flit reassembler.
//
//   npu_network_defines     : network-wide flit format (flit type, VC id,
//                             header, flit) and the `PAYLOAD_W payload width.
//   vn_flit_reassembler_pkg : assembler FSM state encoding and a ceiling
//                             division helper used to size the chunk buffer.
//
// No ports; packages only.
// -----------------------------------------------------------------------------
`ifndef PAYLOAD_W
`define PAYLOAD_W 64
`endif

package npu_network_defines;

   typedef enum logic [1:0] {
      HEAD = 2'd0,
      BODY = 2'd1,
      TAIL = 2'd2,
      HT   = 2'd3
   } flit_type_e;

   typedef enum logic [1:0] {
      VC0 = 2'd0,
      VC1 = 2'd1,
      VC2 = 2'd2,
      VC3 = 2'd3
   } vc_e;

   typedef struct packed {
      flit_type_e flit_type;
      vc_e        vc;
   } flit_header_t;

   typedef struct packed {
      flit_header_t           header;
      logic [`PAYLOAD_W-1:0]  payload;
   } flit_t;

endpackage

package vn_flit_reassembler_pkg;

   typedef enum logic {
      ST_IDLE    = 1'b0,
      ST_COLLECT = 1'b1
   } asm_state_e;

   function automatic int ceil_div(input int num, input int den);
      return (num + den - 1) / den;
   endfunction

endpackage

// File: rtl/vn_flit_reassembler_if.sv
// -----------------------------------------------------------------------------
// Flit-in / packet-out bundle of the virtual-network reassembler.
//
//   flit_valid, flit_in   : router -> reassembler flit stream
//   vn_credit             : reassembler -> router on/off credit
//   packet_valid, packet_body, packet_has_data
//                         : FIFO head presented to the core
//   packet_consumed       : core pops the FIFO head
//   protocol_error        : sticky violation flag
//
// Modports: master = router/core side, slave = reassembler.
// -----------------------------------------------------------------------------
interface vn_flit_reassembler_if
   import npu_network_defines::*;
#(
   parameter int PACKET_BODY_SIZE = 256
) ();

   logic                        flit_valid;
   flit_t                       flit_in;
   logic                        vn_credit;
   logic                        packet_valid;
   logic [PACKET_BODY_SIZE-1:0] packet_body;
   logic                        packet_has_data;
   logic                        packet_consumed;
   logic                        protocol_error;

   modport master (
      output flit_valid, flit_in, packet_consumed,
      input  vn_credit, packet_valid, packet_body, packet_has_data, protocol_error
   );

   modport slave (
      input  flit_valid, flit_in, packet_consumed,
      output vn_credit, packet_valid, packet_body, packet_has_data, protocol_error
   );

endinterface

// File: rtl/vn_flit_reassembler_sync_fifo.sv
// -----------------------------------------------------------------------------
// sync_fifo: single-clock FIFO with synchronous active-low reset.
//
//   clk, rst_n      : clock, synchronous reset (asserted at 0)
//   push_i, data_i  : write request and data; ignored when full unless a pop
//                     happens in the same cycle
//   pop_i           : read request; ignored when empty
//   data_o          : head entry (combinational)
//   empty_o, full_o : occupancy flags
//   almost_full_o   : free entries <= ALMOST_FULL_THRESHOLD
// -----------------------------------------------------------------------------
module sync_fifo #(
   parameter int WIDTH                 = 8,
   parameter int DEPTH                 = 4,
   parameter int ALMOST_FULL_THRESHOLD = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push_i,
   input  logic [WIDTH-1:0] data_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] data_o,
   output logic             empty_o,
   output logic             full_o,
   output logic             almost_full_o
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
   logic [CNT_W-1:0] count_q;
   logic             do_push, do_pop;

   assign empty_o       = (count_q == '0);
   assign full_o        = (count_q == CNT_W'(DEPTH));
   assign almost_full_o = ((DEPTH - int'(count_q)) <= ALMOST_FULL_THRESHOLD);
   assign data_o        = mem_q[rd_ptr_q];

   // A pop in the same cycle frees the slot, so a full FIFO still accepts.
   assign do_pop  = pop_i & ~empty_o;
   assign do_push = push_i & (~full_o | do_pop);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + 1'b1;
         if (do_pop)  rd_ptr_q <= (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

   // NOTE: storage is not reset; the pointers and count alone decide what is valid.
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= data_i;
   end

endmodule

// File: rtl/vn_flit_reassembler.sv
// -----------------------------------------------------------------------------
// vn_flit_reassembler: receive stage for one virtual channel. Collects
// HEAD/BODY/TAIL trains or single HT flits, rebuilds the packet body and
// queues complete packets for the core; exports an on/off credit.
//
//   clk     : clock
//   reset   : synchronous reset, active low
//   enable  : 0 = capture nothing and withdraw credit
//   bus     : vn_flit_reassembler_if.slave (flits in, packets out, credit,
//             protocol_error)
//
// Optional build macro: NPU_VN_PROTOCOL_CHECK_EN adds the sticky
// protocol_error checks; without it protocol_error is tied to 0.
// -----------------------------------------------------------------------------
module vn_flit_reassembler
   import npu_network_defines::*;
   import vn_flit_reassembler_pkg::*;
#(
   parameter vc_e VCID                         = VC0,
   parameter int  PACKET_BODY_SIZE             = 256,
   parameter int  PACKET_FIFO_SIZE             = 4,
   parameter int  PACKET_ALMOST_FULL_THRESHOLD = 1
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 enable,
   vn_flit_reassembler_if.slave bus
);

   localparam int PAYLOAD_W = `PAYLOAD_W;
   localparam int FLIT_NUMB = ceil_div(PACKET_BODY_SIZE, PAYLOAD_W);
   localparam int CNT_W     = $clog2(FLIT_NUMB) + 1;
   // The buffer holds whole chunks; the last one is cut to the body width on enqueue.
   localparam int BUF_W     = FLIT_NUMB * PAYLOAD_W;
   localparam logic [CNT_W-1:0] LAST_CHUNK = CNT_W'(FLIT_NUMB - 1);

   typedef struct packed {
      logic [PACKET_BODY_SIZE-1:0] packet_body;
      logic                        packet_has_data;
   } fifo_entry_t;

   asm_state_e       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [BUF_W-1:0] buf_q, buf_d;
   logic             credit_q;

   logic                 accept;
   flit_type_e           flit_type;
   logic [PAYLOAD_W-1:0] payload;
   logic [BUF_W-1:0]     single_chunk;
   logic [BUF_W-1:0]     merged;
   logic                 asm_push;
   fifo_entry_t          push_entry, head_entry;
   logic                 fifo_push, fifo_pop;
   logic                 fifo_empty, fifo_full, fifo_almost_full;
`ifdef NPU_VN_PROTOCOL_CHECK_EN
   logic                 err_set;
   logic                 overflow;
   logic                 err_q;
`endif

   assign accept       = bus.flit_valid & enable & (bus.flit_in.header.vc == VCID);
   assign flit_type    = bus.flit_in.header.flit_type;
   assign payload      = bus.flit_in.payload;
   assign single_chunk = BUF_W'(payload);

   // -------------------------------------------------------------------------
   // Assembler FSM: next state, buffer update and enqueue request
   // -------------------------------------------------------------------------
   always_comb begin
      // NOTE: every signal gets a default first so no path can infer a latch.
      state_d    = state_q;
      cnt_d      = cnt_q;
      buf_d      = buf_q;
      asm_push   = 1'b0;
      push_entry = '0;
`ifdef NPU_VN_PROTOCOL_CHECK_EN
      err_set    = 1'b0;
`endif
      // Current buffer with the incoming payload dropped into chunk[cnt_q].
      merged = buf_q;
      if (cnt_q <= LAST_CHUNK) merged[int'(cnt_q)*PAYLOAD_W +: PAYLOAD_W] = payload;

      if (accept) begin
         unique case (flit_type)
            HT: begin
`ifdef NPU_VN_PROTOCOL_CHECK_EN
               if (state_q == ST_COLLECT) err_set = 1'b1;
`endif
               // Any partial packet is abandoned; the HT stands alone.
               asm_push                   = 1'b1;
               push_entry.packet_body     = single_chunk[PACKET_BODY_SIZE-1:0];
               push_entry.packet_has_data = 1'b0;
               state_d                    = ST_IDLE;
               cnt_d                      = '0;
            end
            HEAD: begin
`ifdef NPU_VN_PROTOCOL_CHECK_EN
               if (state_q == ST_COLLECT) err_set = 1'b1;
`endif
               // Clearing the unused chunks here keeps short trains zero-padded.
               buf_d   = single_chunk;
               cnt_d   = CNT_W'(1);
               state_d = ST_COLLECT;
            end
            BODY: begin
`ifdef NPU_VN_PROTOCOL_CHECK_EN
               if (state_q == ST_IDLE) begin
                  err_set = 1'b1;
               end else if (cnt_q >= LAST_CHUNK) begin
                  // The last chunk is reserved for the TAIL.
                  err_set = 1'b1;
                  state_d = ST_IDLE;
                  cnt_d   = '0;
               end else begin
                  buf_d = merged;
                  cnt_d = cnt_q + 1'b1;
               end
`else
               if (cnt_q < LAST_CHUNK) begin
                  buf_d = merged;
                  cnt_d = cnt_q + 1'b1;
               end
`endif
            end
            TAIL: begin
`ifdef NPU_VN_PROTOCOL_CHECK_EN
               if (state_q == ST_IDLE) begin
                  err_set = 1'b1;
               end else begin
                  asm_push                   = 1'b1;
                  push_entry.packet_body     = merged[PACKET_BODY_SIZE-1:0];
                  push_entry.packet_has_data = 1'b1;
                  state_d                    = ST_IDLE;
                  cnt_d                      = '0;
               end
`else
               asm_push                   = 1'b1;
               push_entry.packet_body     = merged[PACKET_BODY_SIZE-1:0];
               push_entry.packet_has_data = 1'b1;
               state_d                    = ST_IDLE;
               cnt_d                      = '0;
`endif
            end
         endcase
      end
   end

   // -------------------------------------------------------------------------
   // State registers and credit
   // -------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments so every register sees pre-edge values.
      if (!reset) begin
         state_q  <= ST_IDLE;
         cnt_q    <= '0;
         buf_q    <= '0;
         credit_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         buf_q    <= buf_d;
         // Registered from current occupancy, so it trails it by one cycle.
         credit_q <= enable & ~fifo_almost_full;
      end
   end

   // -------------------------------------------------------------------------
   // Packet queue
   // -------------------------------------------------------------------------
   assign fifo_pop  = bus.packet_consumed & ~fifo_empty;
   // A packet arriving at a full queue with no pop is dropped here.
   assign fifo_push = asm_push & (~fifo_full | fifo_pop);

   sync_fifo #(
      .WIDTH                 (PACKET_BODY_SIZE + 1),
      .DEPTH                 (PACKET_FIFO_SIZE),
      .ALMOST_FULL_THRESHOLD (PACKET_ALMOST_FULL_THRESHOLD)
   ) u_packet_fifo (
      .clk           (clk),
      .rst_n         (reset),
      .push_i        (fifo_push),
      .data_i        (push_entry),
      .pop_i         (fifo_pop),
      .data_o        (head_entry),
      .empty_o       (fifo_empty),
      .full_o        (fifo_full),
      .almost_full_o (fifo_almost_full)
   );

   assign bus.packet_valid    = ~fifo_empty;
   assign bus.packet_body     = head_entry.packet_body;
   assign bus.packet_has_data = head_entry.packet_has_data;
   assign bus.vn_credit       = credit_q;

   // -------------------------------------------------------------------------
   // Sticky protocol error
   // -------------------------------------------------------------------------
`ifdef NPU_VN_PROTOCOL_CHECK_EN
   assign overflow = asm_push & fifo_full & ~fifo_pop;

   always_ff @(posedge clk) begin
      if (!reset)                   err_q <= 1'b0;
      else if (err_set | overflow) err_q <= 1'b1;
   end

   assign bus.protocol_error = err_q;
`else
   assign bus.protocol_error = 1'b0;
`endif

endmodule

// File: doc/vn_flit_reassembler.md
Name: vn_flit_reassembler

Overview:
- Per-virtual-network receive stage, directly downstream of the router local-port VC and upstream of the cache controller or directory.
- Collects flits of one VC (HEAD/BODY/TAIL or single-flit HT), rebuilds the PACKET_BODY_SIZE packet body and queues complete packets in a FIFO for the core.
- Exports an on/off credit to the router. It is the receive-side counterpart of the packet-to-flit splitter.

Parameters:
- VCID, VC0, virtual channel this instance accepts; flits tagged with any other VC are ignored.
- PACKET_BODY_SIZE, 256, reassembled body width in bits.
- PACKET_FIFO_SIZE, 4, depth of the complete-packet FIFO in packets.
- PACKET_ALMOST_FULL_THRESHOLD, 1, credit is withdrawn when free entries <= this value.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-low reset (asserted at 0).
- enable  in  1  when 0, no flit is captured and credit is 0.
- flit_valid  in  1  router presents a flit.
- flit_in  in  $bits(flit_t)  header (flit_type, vc, ...) plus payload of `PAYLOAD_W bits.
- vn_credit  out  1  router may send flits on this VC.
- packet_valid  out  1  FIFO head holds a complete packet.
- packet_body  out  PACKET_BODY_SIZE  reassembled body at FIFO head.
- packet_has_data  out  1  1 = built from a HEAD..TAIL train, 0 = built from an HT flit.
- packet_consumed  in  1  core pops the FIFO head; ignored when packet_valid=0.
- protocol_error  out  1  sticky protocol violation flag.

Behaviour:
- FLIT_NUMB = ceil(PACKET_BODY_SIZE/`PAYLOAD_W). Chunk counter width is $clog2(FLIT_NUMB)+1. Chunk k fills bits [k*PAYLOAD_W +: PAYLOAD_W]. The last chunk is truncated to the body width.
- Accept condition: flit_valid & enable & (flit_in.header.vc == VCID).
- Reset values: FSM=IDLE, counter=0, body buffer=0, FIFO empty, packet_valid=0, vn_credit=0, protocol_error=0. vn_credit rises in the first cycle after reset is released.
- A reset asserted mid-packet discards the partial body and all queued packets.
- FSM IDLE:
  - HT: enqueue {payload in chunk 0, other chunks 0, has_data=0} on the same edge.
  - HEAD: write chunk 0, counter=1, go to COLLECT. Unused chunks are cleared at HEAD.
- FSM COLLECT:
  - BODY: write chunk[counter], counter+1.
  - TAIL: enqueue the buffer merged with the incoming chunk into chunk[counter], has_data=1, go to IDLE.
- Latency: a TAIL or HT accepted in cycle T gives packet_valid=1 in cycle T+1.
- Combinational output: packet_body and packet_has_data show the FIFO head.
- Simultaneous enqueue and dequeue:
  - Allowed when the FIFO is full: the pop frees the slot.
  - Allowed when the FIFO is empty: the new packet appears in the next cycle.
- vn_credit = enable & ~reset_state & (free FIFO entries > PACKET_ALMOST_FULL_THRESHOLD). It is registered, so it updates one cycle after occupancy changes.
- Flits arriving while vn_credit=0 are still accepted. This is the router in-flight slack.
- Enqueue into a full FIFO without a simultaneous pop is an overflow: the packet is dropped and the error path applies.
- The counter never wraps. A BODY arriving when counter==FLIT_NUMB-1 is a violation.

Optional Feature:
- Macro: NPU_VN_PROTOCOL_CHECK_EN.
- Defined, each of the following sets protocol_error, which stays set until reset:
  - BODY or TAIL in IDLE: flit dropped.
  - HEAD or HT in COLLECT: partial packet discarded, new flit processed as if in IDLE.
  - Chunk overflow: flit dropped, FSM returns to IDLE.
  - FIFO overflow.
- Undefined: protocol_error is tied to 0 and no checks are built.
  - BODY/TAIL in IDLE are treated as writes at the current counter.
  - Chunk overflow writes are ignored.
  - Overflow is a don't-care.

Decomposition:
- Shared network package (npu_network_defines): flit_t, flit_header_t, flit type enum (HEAD, BODY, TAIL, HT), VC enum, `PAYLOAD_W. Nothing new is added to it.
- Local typedef for the FIFO entry: {packet_body, packet_has_data}.
- Sub-module: reuse sync_fifo for the packet queue.
  - WIDTH = PACKET_BODY_SIZE+1.
  - almost_full drives the credit logic.
- The assembler FSM and buffer stay in this module; no further sub-module.

Test Plan:
1. HT flit, payload 64'hDEAD_BEEF (PAYLOAD_W=64, body 256) -> next cycle packet_valid=1, body[63:0]=DEADBEEF, upper bits 0, has_data=0.
2. HEAD A, BODY B, BODY C, TAIL D -> one packet {D,C,B,A}, has_data=1, valid exactly 1 cycle after TAIL; back-to-back HT in the cycle after TAIL is also queued.
3. Send 4 HT packets with no pops (SIZE=4, THR=1) -> vn_credit falls the cycle after the 3rd enqueue; one pop -> credit returns one cycle later.
4. Flits tagged VC1 while VCID=VC0 -> ignored, no packet, no error.
5. With NPU_VN_PROTOCOL_CHECK_EN: BODY in IDLE -> protocol_error=1 and sticky; HEAD,BODY,HEAD,TAIL -> error and only the second packet is delivered.
6. Reset asserted after HEAD,BODY with 2 queued packets -> next cycle packet_valid=0, vn_credit=0; new HT after release is delivered intact.
